mem_bridge: RTL and testbench



---
 rtl/mem_bridge_pkg.sv | 39 +++
 rtl/mem_bridge_align.sv | 51 +++++
 rtl/mem_bridge.sv | 174 +++++++++++++++++
 tb/tb_mem_bridge.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_bridge_pkg.sv
// Shared types and helpers for the memory-side bridge.
package mem_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_ERR   = 3'd4
  } mem_bridge_state_t;

  // funct3 encodings of load/store size
  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  // True when the requested access cannot be issued on the bus.
  function automatic logic access_err(input logic       rd,
                                      input logic       wr,
                                      input logic [2:0] size,
                                      input logic [1:0] off);
    logic bad;
    bad = rd & wr;
    if (wr) begin
      if (!(size inside {MEM_B, MEM_H, MEM_W})) bad = 1'b1;
    end else begin
      if (!(size inside {MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU})) bad = 1'b1;
    end
    case (size)
      MEM_H, MEM_HU: if (off[0]) bad = 1'b1;
      MEM_W:         if (off != 2'b00) bad = 1'b1;
      default: ;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_bridge_align.sv
// Byte-lane steering: store enables/replication and load extract/extend.
module mem_lane_align
  import mem_bridge_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  size,
  input  logic        we,
  input  logic [31:0] wdata_in,
  input  logic [31:0] rdata_in,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Store side: reads use all lanes, stores shift enables and replicate data.
  always_comb begin
    be    = 4'b1111;
    wdata = wdata_in;
    if (we) begin
      case (size)
        MEM_B: begin
          be    = 4'b0001 << off;
          wdata = {4{wdata_in[7:0]}};
        end
        MEM_H: begin
          be    = 4'b0011 << off;
          wdata = {2{wdata_in[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Load side: pick the addressed lane and sign/zero extend.
  always_comb begin
    byte_sel  = rdata_in[{off, 3'b000} +: 8];
    half_sel  = off[1] ? rdata_in[31:16] : rdata_in[15:0];
    rdata_ext = rdata_in;
    case (size)
      MEM_B:   rdata_ext = {{24{byte_sel[7]}}, byte_sel};
      MEM_BU:  rdata_ext = {24'd0, byte_sel};
      MEM_H:   rdata_ext = {{16{half_sel[15]}}, half_sel};
      MEM_HU:  rdata_ext = {16'd0, half_sel};
      default: rdata_ext = rdata_in;
    endcase
  end

endmodule

// File: rtl/mem_bridge.sv
// Converts core mem_read/mem_write into one req/gnt/rvalid bus transaction.
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  mem_size,
  input  logic [31:0] mar,
  input  logic [31:0] mdr,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic        mem_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  mem_bridge_state_t state_q, state_d;
  logic             req_prev;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       off_q, off_d;
  logic [2:0]       size_q, size_d;
  logic             we_q, we_d;
  logic             err_q, err_d;

  logic [31:0] rdata_d;
  logic        resp_d, merr_d, req_d, bwe_d;
  logic [31:0] baddr_d, bwdata_d;
  logic [3:0]  bbe_d;

  logic        req_now_c, start_c, timeout_c;
  logic [1:0]  al_off_c;
  logic [2:0]  al_size_c;
  logic        al_we_c;
  logic [3:0]  al_be_c;
  logic [31:0] al_wdata_c, al_rdata_c;

  assign req_now_c = mem_read | mem_write;
  assign start_c   = req_now_c & ~req_prev;
  assign timeout_c = (cnt_q == CNT_W'(TIMEOUT - 1));

  // Aligner sees live inputs while idle (issue setup), latched ones after.
  assign al_off_c  = (state_q == ST_IDLE) ? mar[1:0]  : off_q;
  assign al_size_c = (state_q == ST_IDLE) ? mem_size  : size_q;
  assign al_we_c   = (state_q == ST_IDLE) ? mem_write : we_q;

  mem_lane_align u_align (
    .off       (al_off_c),
    .size      (al_size_c),
    .we        (al_we_c),
    .wdata_in  (mdr),
    .rdata_in  (bus_rdata),
    .be        (al_be_c),
    .wdata     (al_wdata_c),
    .rdata_ext (al_rdata_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    off_d    = off_q;
    size_d   = size_q;
    we_d     = we_q;
    err_d    = err_q;
    rdata_d  = mem_rdata;
    resp_d   = 1'b0;
    merr_d   = 1'b0;
    req_d    = bus_req;
    bwe_d    = bus_we;
    baddr_d  = bus_addr;
    bbe_d    = bus_be;
    bwdata_d = bus_wdata;
    case (state_q)
      ST_IDLE: begin
        if (start_c) begin
          state_d = ST_ISSUE;
          cnt_d   = '0;
          off_d   = mar[1:0];
          size_d  = mem_size;
          we_d    = mem_write;
          err_d   = access_err(mem_read, mem_write, mem_size, mar[1:0]);
          if (!err_d) begin
            req_d    = 1'b1;
            bwe_d    = mem_write;
            baddr_d  = {mar[31:2], 2'b00};
            bbe_d    = al_be_c;
            bwdata_d = al_wdata_c;
          end
        end
      end
      ST_ISSUE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (err_q) begin
          state_d = ST_ERR;
          resp_d  = 1'b1;
          merr_d  = 1'b1;
        end else if (bus_gnt) begin
          state_d = ST_WAIT;
          req_d   = 1'b0;
        end else if (timeout_c) begin
          state_d = ST_ERR;
          req_d   = 1'b0;
          resp_d  = 1'b1;
          merr_d  = 1'b1;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus_rvalid) begin
          state_d = ST_RESP;
          resp_d  = 1'b1;
          if (!we_q) rdata_d = al_rdata_c;
        end else if (timeout_c) begin
          state_d = ST_ERR;
          resp_d  = 1'b1;
          merr_d  = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      req_prev  <= 1'b0;
      cnt_q     <= '0;
      off_q     <= '0;
      size_q    <= '0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      mem_rdata <= '0;
      mem_resp  <= 1'b0;
      mem_err   <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
    end else begin
      state_q   <= state_d;
      req_prev  <= req_now_c;
      cnt_q     <= cnt_d;
      off_q     <= off_d;
      size_q    <= size_d;
      we_q      <= we_d;
      err_q     <= err_d;
      mem_rdata <= rdata_d;
      mem_resp  <= resp_d;
      mem_err   <= merr_d;
      bus_req   <= req_d;
      bus_we    <= bwe_d;
      bus_addr  <= baddr_d;
      bus_be    <= bbe_d;
      bus_wdata <= bwdata_d;
    end
  end

endmodule

// File: tb/tb_mem_bridge.sv
// Directed self-checking bench for mem_bridge.
module tb_mem_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  mem_size = 3'b000;
  logic [31:0] mar = 32'd0;
  logic [31:0] mdr = 32'd0;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        mem_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt = 1'b0;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = 32'd0;

  int n_pass  = 0;
  int n_total = 0;
  int req_seen;

  always #5 clk = ~clk;

  mem_bridge #(.TIMEOUT(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_size   (mem_size),
    .mar        (mar),
    .mdr        (mdr),
    .mem_rdata  (mem_rdata),
    .mem_resp   (mem_resp),
    .mem_err    (mem_err),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_gnt    (bus_gnt),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
  endtask

  // One successful access: gnt in T+1, rvalid in T+2, response in T+3.
  task automatic run_access(input string tag, input logic rd, input logic wr,
                            input logic [2:0] sz, input logic [31:0] addr,
                            input logic [31:0] data, input logic [31:0] rword,
                            input logic [31:0] exp_addr, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
    mem_read = rd; mem_write = wr; mem_size = sz; mar = addr; mdr = data;
    tick();
    check({tag, "_req"},  32'(bus_req), 32'd1);
    check({tag, "_we"},   32'(bus_we), 32'(wr));
    check({tag, "_addr"}, bus_addr, exp_addr);
    check({tag, "_be"},   32'(bus_be), 32'(exp_be));
    if (wr) check({tag, "_wdata"}, bus_wdata, exp_wdata);
    mem_read = 1'b0; mem_write = 1'b0; bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    check({tag, "_req_drop"}, 32'(bus_req), 32'd0);
    check({tag, "_resp_t2"},  32'(mem_resp), 32'd0);
    bus_rvalid = 1'b1; bus_rdata = rword;
    tick();
    bus_rvalid = 1'b0;
    check({tag, "_resp_t3"}, 32'(mem_resp), 32'd1);
    check({tag, "_err"},     32'(mem_err), 32'd0);
    check({tag, "_rdata"},   mem_rdata, exp_rdata);
    tick();
    check({tag, "_resp_t4"}, 32'(mem_resp), 32'd0);
  endtask

  // A rejected access: no bus request, error response in T+2.
  task automatic run_error(input string tag, input logic rd, input logic wr,
                           input logic [2:0] sz, input logic [31:0] addr,
                           input logic [31:0] exp_rdata);
    mem_read = rd; mem_write = wr; mem_size = sz; mar = addr;
    tick();
    mem_read = 1'b0; mem_write = 1'b0;
    check({tag, "_noreq_t1"}, 32'(bus_req), 32'd0);
    check({tag, "_resp_t1"},  32'(mem_resp), 32'd0);
    tick();
    check({tag, "_noreq_t2"}, 32'(bus_req), 32'd0);
    check({tag, "_resp_t2"},  32'(mem_resp), 32'd1);
    check({tag, "_err_t2"},   32'(mem_err), 32'd1);
    check({tag, "_rdata"},    mem_rdata, exp_rdata);
    tick();
    check({tag, "_resp_t3"}, 32'(mem_resp), 32'd0);
  endtask

  initial begin
    // Reset values
    tick();
    tick();
    check("rst_rdata", mem_rdata, 32'd0);
    check("rst_resp",  32'(mem_resp), 32'd0);
    check("rst_err",   32'(mem_err), 32'd0);
    check("rst_req",   32'(bus_req), 32'd0);
    check("rst_we",    32'(bus_we), 32'd0);
    check("rst_addr",  bus_addr, 32'd0);
    check("rst_be",    32'(bus_be), 32'd0);
    check("rst_wdata", bus_wdata, 32'd0);
    rst_n = 1'b1;
    tick();

    // Loads across sizes and lanes
    run_access("lw",  1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF,
               32'h0000_0100, 4'b1111, 32'd0, 32'hDEAD_BEEF);
    run_access("lb",  1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'd0, 32'h80FF_1234,
               32'h0000_0100, 4'b1111, 32'd0, 32'hFFFF_FF80);
    run_access("lbu", 1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'd0, 32'h80FF_1234,
               32'h0000_0100, 4'b1111, 32'd0, 32'h0000_0080);
    run_access("lh",  1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'd0, 32'h80FF_1234,
               32'h0000_0100, 4'b1111, 32'd0, 32'hFFFF_80FF);

    // Stores leave mem_rdata untouched
    run_access("sh",  1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h0000_BEEF, 32'h5555_5555,
               32'h0000_0100, 4'b1100, 32'hBEEF_BEEF, 32'hFFFF_80FF);
    run_access("sb",  1'b0, 1'b1, 3'b000, 32'h0000_0201, 32'h1234_5678, 32'h5555_5555,
               32'h0000_0200, 4'b0010, 32'h7878_7878, 32'hFFFF_80FF);
    run_access("lhu", 1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'd0, 32'h80FF_1234,
               32'h0000_0100, 4'b1111, 32'd0, 32'h0000_80FF);

    // Rejected accesses
    run_error("lw_mis",  1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0000_80FF);
    run_error("rd_wr",   1'b1, 1'b1, 3'b010, 32'h0000_0100, 32'h0000_80FF);
    run_error("ld_bad",  1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0000_80FF);
    run_error("st_bu",   1'b0, 1'b1, 3'b100, 32'h0000_0100, 32'h0000_80FF);

    // Timeout with gnt held low: 8 cycles of bus_req then error response
    mem_read = 1'b1; mem_size = 3'b010; mar = 32'h0000_0200;
    tick();
    mem_read = 1'b0;
    check("to_req_1", 32'(bus_req), 32'd1);
    for (int i = 2; i <= 8; i++) begin
      tick();
      check($sformatf("to_req_%0d", i), 32'(bus_req), 32'd1);
    end
    tick();
    check("to_req_drop", 32'(bus_req), 32'd0);
    check("to_resp",     32'(mem_resp), 32'd1);
    check("to_err",      32'(mem_err), 32'd1);
    tick();
    check("to_resp_end", 32'(mem_resp), 32'd0);

    // Held mem_read: exactly one transaction
    mem_read = 1'b1; mem_size = 3'b010; mar = 32'h0000_0400; bus_gnt = 1'b1;
    req_seen = 0;
    tick();
    if (bus_req) req_seen++;
    tick();
    if (bus_req) req_seen++;
    bus_rvalid = 1'b1; bus_rdata = 32'h1122_3344;
    tick();
    if (bus_req) req_seen++;
    bus_rvalid = 1'b0;
    check("hold_resp",  32'(mem_resp), 32'd1);
    check("hold_rdata", mem_rdata, 32'h1122_3344);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus_req) req_seen++;
      if (mem_resp) req_seen++;
    end
    check("hold_single_txn", 32'(req_seen), 32'd1);
    mem_read = 1'b0; bus_gnt = 1'b0;
    tick();

    // Reset while in WAIT, then a stale rvalid
    mem_read = 1'b1; mem_size = 3'b010; mar = 32'h0000_0300;
    tick();
    mem_read = 1'b0; bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rstw_req",  32'(bus_req), 32'd0);
    check("rstw_resp", 32'(mem_resp), 32'd0);
    bus_rvalid = 1'b1; bus_rdata = 32'hCAFE_F00D;
    tick();
    bus_rvalid = 1'b0;
    check("rstw_stale_resp", 32'(mem_resp), 32'd0);
    tick();
    check("rstw_stale_resp2", 32'(mem_resp), 32'd0);
    check("rstw_rdata",       mem_rdata, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
